normalize_round: RTL and testbench
==================================

Name: normalize_round

Overview:
- Inverse of the partial-product alignment stage in the MAC subsystem.
- Takes the two's-complement sum of aligned partial products (sum relative to max_exp) and returns a normalized sign/leading-one/fraction value plus exponent.
- Uses the same 4-bit pp format as alignment input: bit3 = S, bits2:0 = ld.f1f0.
- Sits after the adder tree; two-stage registered pipeline with valid and Q_frac sideband passthrough.

Parameters:
- SUM_W, 18, width of the two's-complement input sum (15-bit aligned pp plus 3 growth bits for up to 8 addends).
- EXP_W, 6, exponent width (unsigned, bias handled upstream).
- PT_POS, 13, bit index in i_sum whose weight equals 2^max_exp (the leading-one position when exp_diff = 0).

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_sum  input  SUM_W  two's-complement aligned sum
- i_max_exp  input  EXP_W  exponent the sum is aligned to
- i_valid  input  1  i_sum, i_max_exp and i_Q_frac are valid this cycle
- i_Q_frac  input  5  sideband, passed through with data
- o_norm_pp  output  4  {S, ld, f1, f0}
- o_exp  output  EXP_W  result exponent
- o_zero  output  1  result is exact zero
- o_ovf  output  1  exponent overflow, result saturated
- o_unf  output  1  exponent underflow, result flushed to zero
- o_valid  output  1  outputs valid
- o_Q_frac  output  5  delayed i_Q_frac

Behaviour:
- Reset: clock and reset are decided as one clock, i_clk; reset i_rst_n is synchronous and active-low. On a rising i_clk edge with i_rst_n = 0, every pipeline register clears. All outputs, including o_valid and o_Q_frac, read 0 the cycle after reset. Reset mid-operation drops in-flight data with no partial outputs.
- Latency: exactly 2 cycles from i_valid to o_valid. Throughput is 1 per cycle; no stall or backpressure. Registers load every cycle regardless of i_valid; consumers qualify outputs with o_valid.
- Stage 1 (registered):
  - sign = i_sum[SUM_W-1].
  - mag = sign ? (~i_sum + 1) : i_sum, treated as SUM_W-bit unsigned. The most-negative input gives mag = 2^(SUM_W-1), which is correct as unsigned.
  - max_exp, valid and Q_frac are registered alongside.
- Stage 2 (combinational, then registered to outputs):
  - p = index of the most significant 1 in mag.
  - Mantissa: m[2:0] = mag[p:p-2]. Guard G = mag[p-3]. Sticky S = OR of mag[p-4:0]. Indices below 0 read as 0.
  - Round to nearest even: round up when G & (S | m[0]).
  - Increment overflow: if m = 3'b111 rounds up, m = 3'b100 and the exponent gains +1.
  - Exponent: e = max_exp + p - PT_POS (+1 on round carry). Compute in signed EXP_W+3 bits; range is -13..68.
- Priority of results (first match wins):
  1. mag = 0: o_zero = 1, o_norm_pp = 0, o_exp = 0.
  2. e < 0: o_unf = 1, o_norm_pp = 0, o_exp = 0, sign dropped.
  3. e > 2^EXP_W - 1: o_ovf = 1, o_exp = 63, o_norm_pp = {sign, 3'b111}.
  4. Otherwise: o_norm_pp = {sign, m}, o_exp = e[EXP_W-1:0].
- At most one of o_zero, o_ovf and o_unf is set.
- Flags and data are registered together with o_valid. They hold whatever the stage computed even when o_valid = 0.
- Back-to-back valid inputs with differing max_exp each use their own registered max_exp; there is no cross-talk.

Test Plan:
- Positive, no rounding: i_sum = 0x03000, i_max_exp = 20, i_Q_frac = 5'h0A → 2 cycles later o_norm_pp = 4'b0110, o_exp = 20, o_Q_frac = 5'h0A, all flags 0.
- Negative and most-negative: i_sum = 0x3D000 (−0x3000), max 20 → 4'b1110, exp 20. i_sum = 0x20000, max 20 → 4'b1100, exp 24.
- Rounding:
  - i_sum = 0x03C00, max 20 → carry gives 4'b0100, exp 21.
  - i_sum = 0x02400 (tie, even) → 4'b0100, exp 20.
  - i_sum = 0x02C00 (tie, odd) → 4'b0110, exp 20.
  - i_sum = 0x02401 (sticky) → 4'b0101, exp 20.
- Growth and limits:
  - i_sum = 0x08000, max 10 → 4'b0100, exp 12.
  - i_sum = 0x10000, max 62 → o_ovf = 1, exp 63, 4'b0111.
  - i_sum = 0x00001, max 5 → o_unf = 1, outputs 0.
  - i_sum = 0 → o_zero = 1.
- Streaming: 8 consecutive valid inputs with alternating max_exp 0/63 → 8 consecutive o_valid pulses, in order, each correct against a scoreboard.
- Reset mid-flight: i_valid = 1 for 2 cycles, then i_rst_n = 0 for 1 cycle → o_valid = 0 and all outputs 0 on the following cycle; no stale result appears after reset is released.

Source files
------------

// File: rtl/normalize_round.sv
// Normalizes a two's-complement aligned partial-product sum back to a 4-bit
// sign/leading-one/fraction value plus exponent, with round-to-nearest-even.
module normalize_round #(
  parameter int unsigned SUM_W  = 18,
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned PT_POS = 13
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [SUM_W-1:0] i_sum,
  input  logic [EXP_W-1:0] i_max_exp,
  input  logic             i_valid,
  input  logic [4:0]       i_Q_frac,
  output logic [3:0]       o_norm_pp,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_unf,
  output logic             o_valid,
  output logic [4:0]       o_Q_frac
);

  localparam int unsigned PW = $clog2(SUM_W);
  // Signed working width for the exponent so underflow shows up as a negative value.
  localparam int unsigned EW = EXP_W + 3;
  localparam logic [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

  logic             sign_q;
  logic [SUM_W-1:0] mag_q;
  logic [SUM_W-1:0] mag_d;
  logic [EXP_W-1:0] max_exp_q;
  logic             valid_q;
  logic [4:0]       q_frac_q;

  assign mag_d = i_sum[SUM_W-1] ? (~i_sum + SUM_W'(1)) : i_sum;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sign_q    <= 1'b0;
      mag_q     <= '0;
      max_exp_q <= '0;
      valid_q   <= 1'b0;
      q_frac_q  <= '0;
    end else begin
      sign_q    <= i_sum[SUM_W-1];
      mag_q     <= mag_d;
      max_exp_q <= i_max_exp;
      valid_q   <= i_valid;
      q_frac_q  <= i_Q_frac;
    end
  end

  logic [PW-1:0]    lead_pos;
  logic [PW-1:0]    shamt;
  logic [SUM_W-1:0] norm;
  logic [2:0]       mant;
  logic [2:0]       mant_rnd;
  logic             guard;
  logic             sticky;
  logic             rnd_up;
  logic             carry;
  logic [EW-1:0]    exp_s;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (mag_q[i]) lead_pos = PW'(i);
    end
    // Left-justify so the leading one lands at the top; bits below index 0 read as zero.
    shamt    = PW'(SUM_W - 1) - lead_pos;
    norm     = mag_q << shamt;
    mant     = norm[SUM_W-1 -: 3];
    guard    = norm[SUM_W-4];
    sticky   = |norm[SUM_W-5:0];
    rnd_up   = guard & (sticky | mant[0]);
    carry    = rnd_up & (&mant);
    mant_rnd = carry ? 3'b100 : (mant + 3'(rnd_up));
    exp_s    = EW'(max_exp_q) + EW'(lead_pos) - EW'(PT_POS) + EW'(carry);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_norm_pp <= '0;
      o_exp     <= '0;
      o_zero    <= 1'b0;
      o_ovf     <= 1'b0;
      o_unf     <= 1'b0;
      o_valid   <= 1'b0;
      o_Q_frac  <= '0;
    end else begin
      o_valid  <= valid_q;
      o_Q_frac <= q_frac_q;
      o_zero   <= 1'b0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
      if (mag_q == '0) begin
        o_zero    <= 1'b1;
        o_norm_pp <= '0;
        o_exp     <= '0;
      end else if (exp_s[EW-1]) begin
        o_unf     <= 1'b1;
        o_norm_pp <= '0;
        o_exp     <= '0;
      end else if (exp_s > ExpMax) begin
        o_ovf     <= 1'b1;
        o_norm_pp <= {sign_q, 3'b111};
        o_exp     <= '1;
      end else begin
        o_norm_pp <= {sign_q, mant_rnd};
        o_exp     <= exp_s[EXP_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round: hand-computed vectors, streaming and mid-flight reset.
module tb_normalize_round;

  logic        i_clk;
  logic        i_rst_n;
  logic [17:0] i_sum;
  logic [5:0]  i_max_exp;
  logic        i_valid;
  logic [4:0]  i_Q_frac;
  logic [3:0]  o_norm_pp;
  logic [5:0]  o_exp;
  logic        o_zero;
  logic        o_ovf;
  logic        o_unf;
  logic        o_valid;
  logic [4:0]  o_Q_frac;

  int n_cmp = 0;
  int n_err = 0;

  // {valid, norm_pp, exp, zero, ovf, unf, Q_frac}
  logic [18:0] obs;
  assign obs = {o_valid, o_norm_pp, o_exp, o_zero, o_ovf, o_unf, o_Q_frac};

  normalize_round #(
    .SUM_W (18),
    .EXP_W (6),
    .PT_POS(13)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sum    (i_sum),
    .i_max_exp(i_max_exp),
    .i_valid  (i_valid),
    .i_Q_frac (i_Q_frac),
    .o_norm_pp(o_norm_pp),
    .o_exp    (o_exp),
    .o_zero   (o_zero),
    .o_ovf    (o_ovf),
    .o_unf    (o_unf),
    .o_valid  (o_valid),
    .o_Q_frac (o_Q_frac)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One valid beat, then wait until its result is at the outputs (2 rising edges later).
  task automatic drive(input logic [17:0] s, input logic [5:0] e, input logic [4:0] q);
    @(negedge i_clk);
    i_sum     = s;
    i_max_exp = e;
    i_Q_frac  = q;
    i_valid   = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    logic [18:0] ev;
    i_rst_n = 1'b0; i_valid = 1'b0; i_sum = '0; i_max_exp = '0; i_Q_frac = '0;
    repeat (2) @(negedge i_clk);
    ev = '0;
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL reset_state: got %h want %h", obs, ev);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_positive();
    logic [18:0] ev;
    drive(18'h03000, 6'd20, 5'h0A);
    ev = {1'b1, 4'b0110, 6'd20, 3'b000, 5'h0A};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL positive_exact: got %h want %h", obs, ev);
    end
  endtask

  task automatic test_negative();
    logic [18:0] ev;
    drive(18'h3D000, 6'd20, 5'h11);
    ev = {1'b1, 4'b1110, 6'd20, 3'b000, 5'h11};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL negative: got %h want %h", obs, ev);
    end
    drive(18'h20000, 6'd20, 5'h12);
    ev = {1'b1, 4'b1100, 6'd24, 3'b000, 5'h12};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL most_negative: got %h want %h", obs, ev);
    end
  endtask

  task automatic test_rounding();
    logic [18:0] ev;
    drive(18'h03C00, 6'd20, 5'h01);
    ev = {1'b1, 4'b0100, 6'd21, 3'b000, 5'h01};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL round_carry: got %h want %h", obs, ev);
    end
    drive(18'h02400, 6'd20, 5'h02);
    ev = {1'b1, 4'b0100, 6'd20, 3'b000, 5'h02};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL round_tie_even: got %h want %h", obs, ev);
    end
    drive(18'h02C00, 6'd20, 5'h03);
    ev = {1'b1, 4'b0110, 6'd20, 3'b000, 5'h03};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL round_tie_odd: got %h want %h", obs, ev);
    end
    drive(18'h02401, 6'd20, 5'h04);
    ev = {1'b1, 4'b0101, 6'd20, 3'b000, 5'h04};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL round_sticky: got %h want %h", obs, ev);
    end
  endtask

  task automatic test_limits();
    logic [18:0] ev;
    drive(18'h08000, 6'd10, 5'h05);
    ev = {1'b1, 4'b0100, 6'd12, 3'b000, 5'h05};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL growth: got %h want %h", obs, ev);
    end
    drive(18'h10000, 6'd62, 5'h06);
    ev = {1'b1, 4'b0111, 6'd63, 3'b010, 5'h06};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL overflow: got %h want %h", obs, ev);
    end
    drive(18'h00001, 6'd5, 5'h07);
    ev = {1'b1, 4'b0000, 6'd0, 3'b001, 5'h07};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL underflow: got %h want %h", obs, ev);
    end
    drive(18'h00000, 6'd30, 5'h08);
    ev = {1'b1, 4'b0000, 6'd0, 3'b100, 5'h08};
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL zero: got %h want %h", obs, ev);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] ss [8];
    logic [5:0]  ee [8];
    logic [18:0] ev [8];
    logic [18:0] idle;
    ss[0] = 18'h02000; ee[0] = 6'd0;  ev[0] = {1'b1, 4'b0100, 6'd0,  3'b000, 5'd0};
    ss[1] = 18'h02000; ee[1] = 6'd63; ev[1] = {1'b1, 4'b0100, 6'd63, 3'b000, 5'd1};
    ss[2] = 18'h03000; ee[2] = 6'd0;  ev[2] = {1'b1, 4'b0110, 6'd0,  3'b000, 5'd2};
    ss[3] = 18'h04000; ee[3] = 6'd63; ev[3] = {1'b1, 4'b0111, 6'd63, 3'b010, 5'd3};
    ss[4] = 18'h01000; ee[4] = 6'd0;  ev[4] = {1'b1, 4'b0000, 6'd0,  3'b001, 5'd4};
    ss[5] = 18'h3E000; ee[5] = 6'd63; ev[5] = {1'b1, 4'b1100, 6'd63, 3'b000, 5'd5};
    ss[6] = 18'h3C000; ee[6] = 6'd0;  ev[6] = {1'b1, 4'b1100, 6'd1,  3'b000, 5'd6};
    ss[7] = 18'h00000; ee[7] = 6'd63; ev[7] = {1'b1, 4'b0000, 6'd0,  3'b100, 5'd7};
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (i >= 2) begin
        n_cmp++;
        if (obs !== ev[i-2]) begin
          n_err++; $display("FAIL stream_%0d: got %h want %h", i - 2, obs, ev[i-2]);
        end
      end
      if (i < 8) begin
        i_sum = ss[i]; i_max_exp = ee[i]; i_Q_frac = 5'(i); i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
    end
    @(negedge i_clk);
    idle = {18'h0, 1'b1};
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_end_valid: got %b want 0 (%h)", o_valid, idle);
    end
  endtask

  task automatic test_reset_midflight();
    logic [18:0] ev;
    @(negedge i_clk);
    i_sum = 18'h03000; i_max_exp = 6'd20; i_Q_frac = 5'h1F; i_valid = 1'b1;
    @(negedge i_clk);
    i_sum = 18'h3D000; i_Q_frac = 5'h1E;
    @(negedge i_clk);
    i_valid = 1'b0; i_rst_n = 1'b0;
    @(negedge i_clk);
    ev = '0;
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL reset_midflight: got %h want %h", obs, ev);
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_no_stale_%0d: got %b want 0", i, o_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_rounding();
    test_limits();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
